// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and constants for the simulation-side SRAM responder.
package dbus_sram_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    localparam logic [63:0] DBUS_SRAM_BASE = 64'h8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } resp_state_e;

endpackage

// File: rtl/dbus_sram_array.sv
// 64-bit synchronous RAM: byte-enabled bus write port, full-word backdoor write port
// (backdoor wins on a same-index collision) and one registered read port.
module sram_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            bus_we_i,
    input  logic [IdxW-1:0] bus_idx_i,
    input  logic [7:0]      bus_be_i,
    input  logic [63:0]     bus_wdata_i,
    input  logic            init_we_i,
    input  logic [IdxW-1:0] init_idx_i,
    input  logic [63:0]     init_wdata_i,
    input  logic            rd_en_i,
    input  logic            rd_clr_i,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [63:0]     rd_data_o
);

    logic [63:0] mem_q [DEPTH_WORDS];
    logic [63:0] rd_data_q;

    // The backdoor assignment comes last so it overrides a bus write to the same word.
    always_ff @(posedge clk) begin
        if (bus_we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (bus_be_i[b]) begin
                    mem_q[bus_idx_i][8*b +: 8] <= bus_wdata_i[8*b +: 8];
                end
            end
        end
        if (init_we_i) begin
            mem_q[init_idx_i] <= init_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_clr_i) begin
            rd_data_q <= 64'h0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: one transaction at a time, writes commit at accept,
// data_ok pulses LATENCY cycles after the accept cycle.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = DBUS_SRAM_BASE,
    parameter int unsigned LATENCY     = 2,
    localparam int unsigned IdxW       = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  dbus_req_t       dreq,
    output dbus_resp_t      dresp,
    input  logic            init_en,
    input  logic [IdxW-1:0] init_idx,
    input  logic [63:0]     init_data
);

    localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);
    localparam logic [63:0] Span    = 64'(DEPTH_WORDS) << 3;

    resp_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  strobe_q, strobe_d;

    logic [63:0]     src_addr, src_off;
    logic [7:0]      src_strobe;
    logic            src_in_range;
    logic [IdxW-1:0] src_idx;
    logic            enter_resp, bus_we, rd_en, rd_clr;
    logic [63:0]     rd_data;
    logic            unused_req;

    assign unused_req = ^dreq.size;

    // In IDLE the live request is decoded so a write can commit at the accept edge.
    assign src_addr     = (state_q == StIdle) ? dreq.addr : addr_q;
    assign src_strobe   = (state_q == StIdle) ? dreq.strobe : strobe_q;
    assign src_off      = src_addr - BASE_ADDR;
    assign src_in_range = (src_addr >= BASE_ADDR) && (src_off < Span);
    assign src_idx      = src_off[IdxW+2:3];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        strobe_d   = strobe_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    strobe_d = dreq.strobe;
                    cnt_d    = CntLoad;
                    if (LATENCY > 1) begin
                        state_d = StWait;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus_we = !reset && (state_q == StIdle) && dreq.valid && (dreq.strobe != 8'h0)
                    && src_in_range;
    assign rd_en  = !reset && enter_resp && (src_strobe == 8'h0) && src_in_range;
    assign rd_clr = reset || (state_q == StResp) || (enter_resp && !rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= 64'h0;
            strobe_q <= 8'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
        end
    end

    sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk         (clk),
        .bus_we_i    (bus_we),
        .bus_idx_i   (src_idx),
        .bus_be_i    (dreq.strobe),
        .bus_wdata_i (dreq.data),
        .init_we_i   (init_en),
        .init_idx_i  (init_idx),
        .init_wdata_i(init_data),
        .rd_en_i     (rd_en),
        .rd_clr_i    (rd_clr),
        .rd_idx_i    (src_idx),
        .rd_data_o   (rd_data)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = !reset && (state_q == StIdle) && dreq.valid;
        dresp.data_ok = (state_q == StResp);
        dresp.data    = rd_data;
    end

endmodule
